// File: rtl/slow_division.sv
// Iterative unsigned restoring divider: one quotient bit per enabled clock,
// start/busy/done handshake, results held until the next completion.
module slow_division #(
  parameter int size = 16
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_enable,
  input  logic            i_start,
  input  logic [size-1:0] i_dividend,
  input  logic [size-1:0] i_divisor,
  output logic            o_busy,
  output logic            o_done,
  output logic [size-1:0] o_quotient,
  output logic [size-1:0] o_remainder,
  output logic            o_div_by_zero
);

  // state  | meaning
  // S_IDLE | waiting for an enabled start; done pulse lives here
  // S_BUSY | one restoring iteration per enabled edge
  typedef enum logic {S_IDLE, S_BUSY} state_t;

  localparam int CW = $clog2(size);

  state_t          r_state;
  state_t          w_next_state;
  logic [size-1:0] r_rem;
  logic [size-1:0] r_shift;
  logic [size-1:0] r_divisor;
  logic [size-1:0] r_quotient;
  logic [size-1:0] r_remainder;
  logic [CW-1:0]   r_cnt;
  logic            r_done;
  logic            r_dbz;

  logic [size:0]   w_trial;
  logic [size:0]   w_diff;
  logic            w_qbit;
  logic [size-1:0] w_rem_next;
  logic            w_last;
  logic            w_accept;

  // Both operands are below 2^(size+1), so a clear borrow bit means trial >= divisor.
  assign w_trial    = {r_rem, r_shift[size-1]};
  assign w_diff     = w_trial - {1'b0, r_divisor};
  assign w_qbit     = ~w_diff[size];
  assign w_rem_next = w_qbit ? w_diff[size-1:0] : w_trial[size-1:0];
  assign w_last     = (r_cnt == CW'(size - 1));
  assign w_accept   = i_enable && i_start && (r_state == S_IDLE);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (i_enable) begin
      case (r_state)
        S_IDLE:  if (i_start) w_next_state = S_BUSY;
        S_BUSY:  if (w_last)  w_next_state = S_IDLE;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_busy        = (r_state == S_BUSY);
    o_done        = r_done;
    o_quotient    = r_quotient;
    o_remainder   = r_remainder;
    o_div_by_zero = r_dbz;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_rem       <= '0;
      r_shift     <= '0;
      r_divisor   <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_done      <= 1'b0;
      r_dbz       <= 1'b0;
    end else if (i_enable) begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_shift   <= i_dividend;
        r_divisor <= i_divisor;
        r_rem     <= '0;
        r_cnt     <= '0;
      end else if (r_state == S_BUSY) begin
        r_rem   <= w_rem_next;
        r_shift <= {r_shift[size-2:0], w_qbit};
        r_cnt   <= r_cnt + CW'(1);
        if (w_last) begin
          r_quotient  <= {r_shift[size-2:0], w_qbit};
          r_remainder <= w_rem_next;
          r_dbz       <= (r_divisor == '0);
          r_done      <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_slow_division.sv
// Bench for slow_division: cycle-level reference model built from integer
// division plus directed scenarios with literal expected results.
module tb_slow_division;

  localparam int SIZE = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            enable;
  logic            start;
  logic [SIZE-1:0] dividend;
  logic [SIZE-1:0] divisor;
  logic            o_busy;
  logic            o_done;
  logic [SIZE-1:0] o_quotient;
  logic [SIZE-1:0] o_remainder;
  logic            o_div_by_zero;

  int total = 0;
  int bad   = 0;
  logic chk_on = 1'b0;

  slow_division #(.size(SIZE)) dut (
    .i_clk         (clk),
    .i_reset       (rst_n),
    .i_enable      (enable),
    .i_start       (start),
    .i_dividend    (dividend),
    .i_divisor     (divisor),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_quotient    (o_quotient),
    .o_remainder   (o_remainder),
    .o_div_by_zero (o_div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: a division is a countdown of SIZE enabled edges whose
  // result is plain integer arithmetic on the captured operands.
  logic            m_busy, m_done, m_dbz;
  logic [SIZE-1:0] m_q, m_r, m_a, m_b;
  int              m_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_dbz <= 1'b0;
      m_q <= '0; m_r <= '0; m_a <= '0; m_b <= '0; m_left <= 0;
    end else if (enable) begin
      m_done <= 1'b0;
      if (!m_busy) begin
        if (start) begin
          m_busy <= 1'b1;
          m_left <= SIZE;
          m_a    <= dividend;
          m_b    <= divisor;
        end
      end else if (m_left == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_dbz  <= (m_b == 0);
        m_q    <= (m_b == 0) ? {SIZE{1'b1}} : m_a / m_b;
        m_r    <= (m_b == 0) ? m_a : m_a % m_b;
      end else begin
        m_left <= m_left - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("busy",        32'(o_busy),        32'(m_busy));
      check("done",        32'(o_done),        32'(m_done));
      check("quotient",    32'(o_quotient),    32'(m_q));
      check("remainder",   32'(o_remainder),   32'(m_r));
      check("div_by_zero", 32'(o_div_by_zero), 32'(m_dbz));
    end
  end

  // Drive a start for one edge; on return the request edge has passed.
  task automatic kick(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0;
    dividend = $urandom; divisor = $urandom;
  endtask

  task automatic wait_done(inout int n, input int limit);
    while (!o_done && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 32'(o_done), 32'd1);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; enable = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    chk_on = 1'b1;
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_q",    32'(o_quotient), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 100 / 7
    kick(16'd100, 16'd7);
    check("busy_after_start", 32'(o_busy), 32'd1);
    n = 0; wait_done(n, 40);
    check("lat_100_7", 32'(n), 32'd16);
    check("q_100_7", 32'(o_quotient), 32'd14);
    check("r_100_7", 32'(o_remainder), 32'd2);
    check("busy_in_done", 32'(o_busy), 32'd0);

    // 0xFFFF / 1 then 5 / 9
    kick(16'hFFFF, 16'd1);
    n = 0; wait_done(n, 40);
    check("q_ffff_1", 32'(o_quotient), 32'hFFFF);
    check("r_ffff_1", 32'(o_remainder), 32'd0);
    kick(16'd5, 16'd9);
    n = 0; wait_done(n, 40);
    check("q_5_9", 32'(o_quotient), 32'd0);
    check("r_5_9", 32'(o_remainder), 32'd5);

    // divide by zero, then 20 / 4 with a frozen done pulse
    kick(16'd1234, 16'd0);
    n = 0; wait_done(n, 40);
    check("lat_dbz", 32'(n), 32'd16);
    check("q_dbz", 32'(o_quotient), 32'hFFFF);
    check("r_dbz", 32'(o_remainder), 32'd1234);
    check("flag_dbz", 32'(o_div_by_zero), 32'd1);
    kick(16'd20, 16'd4);
    n = 0; wait_done(n, 40);
    check("q_20_4", 32'(o_quotient), 32'd5);
    check("r_20_4", 32'(o_remainder), 32'd0);
    check("flag_20_4", 32'(o_div_by_zero), 32'd0);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check("done_frozen", 32'(o_done), 32'd1);
    enable = 1'b1;
    @(negedge clk);
    check("done_released", 32'(o_done), 32'd0);

    // ignored start while busy plus a 3-cycle enable gap
    kick(16'd100, 16'd7);
    n = 0;
    repeat (4) begin @(negedge clk); n++; end
    start = 1'b1; dividend = 16'd50; divisor = 16'd5;
    @(negedge clk); n++;
    start = 1'b0; enable = 1'b0;
    repeat (3) begin @(negedge clk); n++; end
    enable = 1'b1;
    wait_done(n, 60);
    check("lat_gap", 32'(n), 32'd19);
    check("q_gap", 32'(o_quotient), 32'd14);
    check("r_gap", 32'(o_remainder), 32'd2);

    // back-to-back: restart in the done cycle
    kick(16'd1000, 16'd3);
    n = 0; wait_done(n, 40);
    check("q_1000_3", 32'(o_quotient), 32'd333);
    check("r_1000_3", 32'(o_remainder), 32'd1);
    kick(16'd77, 16'd10);
    check("hold_q_1000_3", 32'(o_quotient), 32'd333);
    n = 0; wait_done(n, 40);
    check("lat_b2b", 32'(n), 32'd16);
    check("q_77_10", 32'(o_quotient), 32'd7);
    check("r_77_10", 32'(o_remainder), 32'd7);

    // reset mid-division
    kick(16'd100, 16'd7);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(o_busy), 32'd0);
    check("arst_q", 32'(o_quotient), 32'd0);
    check("arst_r", 32'(o_remainder), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (o_done) n++;
    end
    check("no_done_after_rst", 32'(n), 32'd0);
    kick(16'd9, 16'd2);
    n = 0; wait_done(n, 40);
    check("q_9_2", 32'(o_quotient), 32'd4);
    check("r_9_2", 32'(o_remainder), 32'd1);

    // random traffic against the model
    repeat (3000) begin
      enable = ($urandom_range(7) != 0);
      start  = ($urandom_range(2) == 0);
      dividend = $urandom;
      case ($urandom_range(7))
        0:       divisor = '0;
        1, 2, 3: divisor = SIZE'($urandom_range(15));
        default: divisor = $urandom;
      endcase
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/slow_division.md
Name: slow_division

Overview:
- Iterative unsigned restoring divider; the inverse of the codebase's slow multiplier.
- Divides a size-bit dividend by a size-bit divisor. Produces a quotient and remainder in size clock cycles, one quotient bit per cycle.
- Not pipelined: one division in flight at a time.
- start/busy/done handshake so shader and arithmetic units can stall on it.

Parameters:
- size, 16, bit width of dividend, divisor, quotient and remainder (legal values ≥ 2).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- enable  input  1  clock enable; when 0 all internal state and outputs hold
- start  input  1  request a new division; sampled only when idle and enable=1
- dividend  input  size  numerator, captured on accepted start
- divisor  input  size  denominator, captured on accepted start
- busy  output  1  1 while a division is in progress
- done  output  1  one-cycle pulse when results update
- quotient  output  size  result quotient, held until next done
- remainder  output  size  result remainder, held until next done
- div_by_zero  output  1  1 if the last completed division had divisor==0, held with results

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
  - Internal registers (partial remainder, shift register, bit counter, captured divisor) are cleared.
- States:
  - IDLE, BUSY.
  - done is a registered pulse, not a state.
- IDLE:
  - On a rising edge with enable=1 and start=1: capture dividend into the shift register and divisor into the divisor register. Clear the partial remainder to 0 and the counter to 0, then go to BUSY.
  - start=0 or enable=0: stay in IDLE.
- BUSY, each rising edge with enable=1:
  - Form trial = {partial_remainder[size-1:0], shift_msb}. This is size+1 bits wide, so no overflow is possible.
  - If trial ≥ divisor: partial_remainder = trial − divisor and the new quotient bit is 1. Otherwise partial_remainder = trial and the quotient bit is 0.
  - Shift the register left, inserting the quotient bit at the LSB. Increment the counter.
- Completion: on the edge where the counter reaches size−1 (the size-th iteration):
  - The final quotient bit and remainder are written directly to quotient and remainder.
  - div_by_zero is set to (captured divisor==0).
  - done=1 for exactly the next cycle, and state returns to IDLE.
- Latency:
  - A start accepted at edge 0 gives done=1 and valid results after edge size, with enable held high. That is 16 cycles at default size.
  - Each cycle with enable=0 during BUSY adds exactly one cycle.
- busy is 1 from the edge after an accepted start through the completion edge; it is 0 in the done cycle.
- Back-to-back operation:
  - start=1 in the done cycle is accepted, since the state is IDLE.
  - The next done comes size cycles later.
  - Results of the previous division stay visible until then.
- start while busy=1 is ignored. Inputs presented then are not captured and there is no error indication.
- enable=0:
  - Freezes everything, including done.
  - A done pulse that is frozen stays asserted until enable returns and one enabled edge passes.
- Divide by zero:
  - No special path; the restoring algorithm runs normally.
  - Result: quotient = all ones, remainder = dividend, div_by_zero=1, with the same latency as any other division.
- Results are always quotient*divisor + remainder == dividend, with remainder < divisor when divisor≠0.
- Reset asserted mid-division aborts it immediately. Outputs go to their reset values and no done pulse is produced.
- dividend and divisor may change freely after capture without affecting the division in progress.

Test Plan:
- size=16, start with dividend=100, divisor=7 -> busy for 16 cycles, then done=1 for one cycle with quotient=14, remainder=2, div_by_zero=0.
- dividend=0xFFFF, divisor=1 -> quotient=0xFFFF, remainder=0. Then dividend=5, divisor=9 -> quotient=0, remainder=5.
- dividend=1234, divisor=0 -> after 16 cycles quotient=0xFFFF, remainder=1234, div_by_zero=1. A following 20/4 -> quotient=5, remainder=0, div_by_zero=0.
- Start 100/7, then pulse start with 50/5 at cycle 5 and drop enable for 3 cycles mid-operation -> done at cycle 19 with quotient=14, remainder=2. The second request is ignored.
- Start 1000/3, re-assert start with 77/10 in the done cycle -> first result quotient=333, remainder=1. The second done comes 16 cycles later with quotient=7, remainder=7.
- Start 100/7, assert reset low at cycle 8 -> busy, done and the outputs clear asynchronously and no done pulse follows. After release, a fresh 9/2 -> quotient=4, remainder=1.
